// File: rtl/decode_sequencer.sv
// Decode-stage instruction buffer: circular fetch queue feeding a parallel
// decoder bank, with slot throttling, halt truncation and flush recovery.
module decode_sequencer #(
  parameter int DEPTH          = 16,
  parameter int FETCH_WIDTH    = 2,
  parameter int DISPATCH_WIDTH = 2,
  parameter int INST_W         = 32,
  parameter int ADDR_W         = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1),
  localparam int LW = $clog2(DISPATCH_WIDTH + 1)
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     flush,
  input  logic [FETCH_WIDTH-1:0]                   fetch_valid,
  input  logic [FETCH_WIDTH-1:0][INST_W-1:0]       fetch_inst,
  input  logic [FETCH_WIDTH-1:0][ADDR_W-1:0]       fetch_pc,
  output logic                                     fetch_ready,
  output logic [DISPATCH_WIDTH-1:0]                dec_valid,
  output logic [DISPATCH_WIDTH-1:0][INST_W-1:0]    dec_inst,
  output logic [DISPATCH_WIDTH-1:0][ADDR_W-1:0]    dec_pc,
  input  logic [DISPATCH_WIDTH-1:0]                dec_halt,
  input  logic [LW-1:0]                            dispatch_limit,
  output logic [LW-1:0]                            dispatch_count,
  output logic [CW-1:0]                            free_count,
  output logic                                     halted
);

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [INST_W-1:0] inst_q [DEPTH];
  logic [INST_W-1:0] inst_d [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [ADDR_W-1:0] pc_d   [DEPTH];

  logic          push;
  logic          hit;
  logic [PW-1:0] idx;
  int            n_push;
  int            lim;
  int            avail;
  int            pop;

  always_comb begin
    free_count  = CW'(DEPTH) - count_q;
    halted      = (state_q == HALTED);
    fetch_ready = !halted && (int'(free_count) >= FETCH_WIDTH);
    push        = fetch_ready && fetch_valid[0] && !flush;

    n_push = 0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (fetch_valid[i]) n_push = n_push + 1;
    end

    lim = (int'(dispatch_limit) > DISPATCH_WIDTH) ?
          DISPATCH_WIDTH : int'(dispatch_limit);
    if (halted) avail = 0;
    else        avail = (int'(count_q) < lim) ? int'(count_q) : lim;

    // Group ends at the first valid slot the decoder flags as a halt.
    hit = 1'b0;
    pop = avail;
    idx = '0;
    dec_valid = '0;
    dec_inst  = '0;
    dec_pc    = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      idx          = head_q + PW'(i);
      dec_valid[i] = (i < avail);
      dec_inst[i]  = inst_q[idx];
      dec_pc[i]    = pc_q[idx];
      if (!hit && dec_valid[i] && dec_halt[i]) begin
        hit = 1'b1;
        pop = i + 1;
      end
    end
    dispatch_count = LW'(pop);
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = state_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      state_d = RUN;
    end else begin
      if (push) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
          if (fetch_valid[i]) begin
            inst_d[tail_q + PW'(i)] = fetch_inst[i];
            pc_d[tail_q + PW'(i)]   = fetch_pc[i];
          end
        end
        tail_d = tail_q + PW'(n_push);
      end
      head_d  = head_q + PW'(pop);
      count_d = count_q + (push ? CW'(n_push) : '0) - CW'(pop);
      unique case (state_q)
        RUN:     if (hit) state_d = HALTED;
        HALTED:  state_d = HALTED;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= RUN;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    inst_q <= inst_d;
    pc_q   <= pc_d;
  end

endmodule

// File: tb/tb_decode_sequencer.sv
// Scoreboard bench for decode_sequencer: expected dispatch stream queued at
// stimulus time, checked by an independent negedge monitor.
module tb_decode_sequencer;

  localparam logic [31:0] WFI = 32'h1050_0073;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic [1:0]       fetch_valid = '0;
  logic [1:0][31:0] fetch_inst = '0;
  logic [1:0][31:0] fetch_pc = '0;
  logic             fetch_ready;
  logic [1:0]       dec_valid;
  logic [1:0][31:0] dec_inst;
  logic [1:0][31:0] dec_pc;
  logic [1:0]       dec_halt;
  logic [1:0]       dispatch_limit = '0;
  logic [1:0]       dispatch_count;
  logic [4:0]       free_count;
  logic             halted;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  decode_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .fetch_valid    (fetch_valid),
    .fetch_inst     (fetch_inst),
    .fetch_pc       (fetch_pc),
    .fetch_ready    (fetch_ready),
    .dec_valid      (dec_valid),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc),
    .dec_halt       (dec_halt),
    .dispatch_limit (dispatch_limit),
    .dispatch_count (dispatch_count),
    .free_count     (free_count),
    .halted         (halted)
  );

  // Decoder model: WFI decodes as halt.
  always_comb begin
    dec_halt = '0;
    for (int i = 0; i < 2; i++) dec_halt[i] = (dec_inst[i] == WFI);
  end

  function automatic logic [31:0] add_op(input logic [31:0] pc);
    return 32'h0000_0033 | {pc[19:0], 12'h000};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // mask selects which slots are expected to reach the decoders.
  task automatic beat(input logic [1:0] fv, input logic [31:0] pc,
                      input logic [31:0] i0, input logic [31:0] i1,
                      input logic [1:0] mask);
    fetch_valid   = fv;
    fetch_pc[0]   = pc;
    fetch_pc[1]   = pc + 32'd4;
    fetch_inst[0] = i0;
    fetch_inst[1] = i1;
    if (mask[0]) exp_q.push_back('{pc, i0});
    if (mask[1]) exp_q.push_back('{pc + 32'd4, i1});
  endtask

  task automatic add_beat(input logic [31:0] pc, input logic [1:0] mask);
    beat(2'b11, pc, add_op(pc), add_op(pc + 32'd4), mask);
  endtask

  // Monitor: every consumed slot must match the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset && !flush) begin
      for (int i = 0; i < int'(dispatch_count); i++) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL dispatch_extra: slot %0d pc %h, required no dispatch",
                   i, dec_pc[i]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (!dec_valid[i] || dec_pc[i] !== e.pc || dec_inst[i] !== e.inst) begin
            n_bad++;
            $display("FAIL dispatch_slot%0d: got v=%b pc=%h inst=%h, required v=1 pc=%h inst=%h",
                     i, dec_valid[i], dec_pc[i], dec_inst[i], e.pc, e.inst);
          end
        end
      end
    end
  end

  initial begin
    // 1: reset values, then one beat dispatched next cycle
    tick();
    tick();
    reset = 1'b0;
    at_neg();
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_disp_cnt", 32'(dispatch_count), 32'd0);
    chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    chk("rst_free", 32'(free_count), 32'd16);
    chk("rst_halted", 32'(halted), 32'd0);
    tick();
    dispatch_limit = 2'd2;
    add_beat(32'h0, 2'b11);
    at_neg();
    chk("t1_no_bypass", 32'(dec_valid), 32'd0);
    tick();
    fetch_valid = '0;
    at_neg();
    chk("t1_dec_valid", 32'(dec_valid), 32'd3);
    chk("t1_disp_cnt", 32'(dispatch_count), 32'd2);
    tick();
    at_neg();
    chk("t1_free", 32'(free_count), 32'd16);
    chk("t1_dec_idle", 32'(dec_valid), 32'd0);

    // 2: fill to full with no dispatch, overflow beat ignored, drain by 1
    tick();
    dispatch_limit = 2'd0;
    for (int b = 0; b < 8; b++) begin
      add_beat(32'h100 + 32'(b * 8), 2'b11);
      tick();
    end
    add_beat(32'h200, 2'b00);
    at_neg();
    chk("t2_full_ready", 32'(fetch_ready), 32'd0);
    chk("t2_full_free", 32'(free_count), 32'd0);
    chk("t2_full_no_disp", 32'(dec_valid), 32'd0);
    tick();
    fetch_valid = '0;
    dispatch_limit = 2'd1;
    at_neg();
    chk("t2_overflow_free", 32'(free_count), 32'd0);
    chk("t2_limit1_cnt", 32'(dispatch_count), 32'd1);
    chk("t2_limit1_valid", 32'(dec_valid), 32'd1);
    repeat (16) tick();
    dispatch_limit = 2'd0;
    at_neg();
    chk("t2_drained_free", 32'(free_count), 32'd16);

    // 3: ADD, WFI, ADD -> group truncated after WFI, then frozen
    tick();
    beat(2'b11, 32'h300, add_op(32'h300), WFI, 2'b11);
    tick();
    beat(2'b01, 32'h308, add_op(32'h308), 32'h0, 2'b00);
    tick();
    fetch_valid = '0;
    dispatch_limit = 2'd2;
    at_neg();
    chk("t3_disp_cnt", 32'(dispatch_count), 32'd2);
    tick();
    add_beat(32'h380, 2'b00);
    at_neg();
    chk("t3_halted", 32'(halted), 32'd1);
    chk("t3_dec_valid", 32'(dec_valid), 32'd0);
    chk("t3_fetch_ready", 32'(fetch_ready), 32'd0);
    chk("t3_free", 32'(free_count), 32'd15);
    tick();
    fetch_valid = '0;
    at_neg();
    chk("t3_halt_push_ign", 32'(free_count), 32'd15);
    chk("t3_still_halted", 32'(dispatch_count), 32'd0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    at_neg();
    chk("t3_flush_halted", 32'(halted), 32'd0);
    chk("t3_flush_free", 32'(free_count), 32'd16);

    // 4: steady 2-in/2-out across pointer wraps, limit 3 clamped to 2
    tick();
    dispatch_limit = 2'd3;
    for (int c = 0; c < 24; c++) begin
      add_beat(32'h400 + 32'(c * 8), 2'b11);
      at_neg();
      if (c > 0) chk("t4_steady_free", 32'(free_count), 32'd14);
      tick();
    end
    fetch_valid = '0;
    at_neg();
    chk("t4_clamp_cnt", 32'(dispatch_count), 32'd2);
    tick();
    at_neg();
    chk("t4_end_free", 32'(free_count), 32'd16);

    // 5: flush with count 5 and a concurrent beat
    tick();
    dispatch_limit = 2'd0;
    add_beat(32'h500, 2'b00);
    tick();
    add_beat(32'h508, 2'b00);
    tick();
    beat(2'b01, 32'h510, add_op(32'h510), 32'h0, 2'b00);
    tick();
    flush = 1'b1;
    dispatch_limit = 2'd2;
    add_beat(32'h600, 2'b00);
    at_neg();
    chk("t5_pre_free", 32'(free_count), 32'd11);
    tick();
    flush = 1'b0;
    fetch_valid = '0;
    at_neg();
    chk("t5_free", 32'(free_count), 32'd16);
    chk("t5_dec_valid", 32'(dec_valid), 32'd0);
    chk("t5_halted", 32'(halted), 32'd0);
    tick();
    at_neg();
    chk("t5_beat_dropped", 32'(free_count), 32'd16);

    // 6: reset while halted with 7 entries left
    tick();
    dispatch_limit = 2'd0;
    beat(2'b11, 32'h700, WFI, add_op(32'h704), 2'b01);
    tick();
    add_beat(32'h708, 2'b00);
    tick();
    add_beat(32'h710, 2'b00);
    tick();
    add_beat(32'h718, 2'b00);
    tick();
    fetch_valid = '0;
    dispatch_limit = 2'd1;
    at_neg();
    chk("t6_disp_cnt", 32'(dispatch_count), 32'd1);
    tick();
    at_neg();
    chk("t6_halted", 32'(halted), 32'd1);
    chk("t6_free", 32'(free_count), 32'd9);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    at_neg();
    chk("t6_rst_halted", 32'(halted), 32'd0);
    chk("t6_rst_free", 32'(free_count), 32'd16);
    chk("t6_rst_dec_valid", 32'(dec_valid), 32'd0);
    tick();
    at_neg();
    chk("sb_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
